// File: rtl/cache_control_if.sv
// CPU port, physical memory port and datapath control bundle for the L1 cache controller.
// master = controller side, slave = CPU/memory/datapath side.
interface cache_control_if;
  logic        mem_read;
  logic        mem_write;
  logic        mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic        pmem_resp;
  logic [1:0]  hit;
  logic [1:0]  dirty;
  logic        lru;
  logic        way_sel;
  logic        load_data;
  logic        data_src;
  logic        load_tag;
  logic        set_valid;
  logic        set_dirty;
  logic        clr_dirty;
  logic        load_lru;
  logic        lru_in;
  logic        pmem_addr_sel;
  logic [31:0] miss_count;
  logic [31:0] wb_count;

  modport master (
    input  mem_read, mem_write, pmem_resp, hit, dirty, lru,
    output mem_resp, pmem_read, pmem_write, way_sel, load_data, data_src, load_tag,
           set_valid, set_dirty, clr_dirty, load_lru, lru_in, pmem_addr_sel,
           miss_count, wb_count
  );

  modport slave (
    output mem_read, mem_write, pmem_resp, hit, dirty, lru,
    input  mem_resp, pmem_read, pmem_write, way_sel, load_data, data_src, load_tag,
           set_valid, set_dirty, clr_dirty, load_lru, lru_in, pmem_addr_sel,
           miss_count, wb_count
  );
endinterface

// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative write-back L1 cache: sequences hit service,
// dirty-victim writeback and line allocation, and counts misses and writebacks.
module cache_control (
  input logic             clk,
  input logic             rst,
  cache_control_if.master bus
);

  typedef enum logic [1:0] {StIdle, StCheck, StWriteback, StAllocate} state_e;

  state_e      state_q;
  logic        victim_q;
  logic [31:0] miss_count_q, miss_count_d;
  logic [31:0] wb_count_q, wb_count_d;

  logic hit_any;
  logic hit_way;
  logic is_write;

  assign hit_any  = |bus.hit;
  // Way 0 wins on the illegal double hit.
  assign hit_way  = ~bus.hit[0];
  assign is_write = bus.mem_write;

  always_comb begin
    miss_count_d = miss_count_q;
    wb_count_d   = wb_count_q;
    if (state_q == StCheck && !hit_any) miss_count_d = miss_count_q + 32'd1;
    if (state_q == StWriteback && bus.pmem_resp) wb_count_d = wb_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      victim_q     <= 1'b0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      miss_count_q <= miss_count_d;
      wb_count_q   <= wb_count_d;
      unique case (state_q)
        StIdle: begin
          if (bus.mem_read || bus.mem_write) state_q <= StCheck;
        end
        StCheck: begin
          if (hit_any) begin
            state_q <= StIdle;
          end else begin
            // Victim is frozen here so later LRU updates cannot move it.
            victim_q <= bus.lru;
            state_q  <= bus.dirty[bus.lru] ? StWriteback : StAllocate;
          end
        end
        StWriteback: begin
          if (bus.pmem_resp) state_q <= StAllocate;
        end
        StAllocate: begin
          if (bus.pmem_resp) state_q <= StCheck;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.way_sel       = 1'b0;
    bus.load_data     = 1'b0;
    bus.data_src      = 1'b0;
    bus.load_tag      = 1'b0;
    bus.set_valid     = 1'b0;
    bus.set_dirty     = 1'b0;
    bus.clr_dirty     = 1'b0;
    bus.load_lru      = 1'b0;
    bus.lru_in        = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    unique case (state_q)
      StCheck: begin
        if (hit_any) begin
          bus.mem_resp = 1'b1;
          bus.load_lru = 1'b1;
          bus.lru_in   = ~hit_way;
          bus.way_sel  = hit_way;
          if (is_write) begin
            bus.load_data = 1'b1;
            bus.set_dirty = 1'b1;
          end
        end
      end
      StWriteback: begin
        bus.way_sel       = victim_q;
        bus.pmem_addr_sel = 1'b1;
        bus.pmem_write    = 1'b1;
      end
      StAllocate: begin
        bus.way_sel   = victim_q;
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          bus.load_data = 1'b1;
          bus.data_src  = 1'b1;
          bus.load_tag  = 1'b1;
          bus.set_valid = 1'b1;
          bus.clr_dirty = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.miss_count = miss_count_q;
  assign bus.wb_count   = wb_count_q;

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: directed scenarios plus randomized requests checked against a
// cycle-count model of hit, clean-miss and dirty-miss sequences.
`timescale 1ns/1ps
module tb_cache_control;
  logic clk = 1'b0;
  logic rst = 1'b1;

  cache_control_if bus ();
  cache_control dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic mem_resp;  logic pmem_read; logic pmem_write; logic way_sel;   logic load_data;
    logic data_src;  logic load_tag;  logic set_valid;  logic set_dirty; logic clr_dirty;
    logic load_lru;  logic lru_in;    logic pmem_addr_sel;
  } ctl_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] miss_m   = '0;
  logic [31:0] wb_m     = '0;

  function automatic ctl_t observe();
    ctl_t c;
    c.mem_resp  = bus.mem_resp;  c.pmem_read = bus.pmem_read; c.pmem_write = bus.pmem_write;
    c.way_sel   = bus.way_sel;   c.load_data = bus.load_data; c.data_src   = bus.data_src;
    c.load_tag  = bus.load_tag;  c.set_valid = bus.set_valid; c.set_dirty  = bus.set_dirty;
    c.clr_dirty = bus.clr_dirty; c.load_lru  = bus.load_lru;  c.lru_in     = bus.lru_in;
    c.pmem_addr_sel = bus.pmem_addr_sel;
    return c;
  endfunction

  function automatic ctl_t hit_ctl(input logic w, input logic wr);
    ctl_t c = '0;
    c.mem_resp = 1'b1; c.load_lru = 1'b1; c.way_sel = w; c.lru_in = ~w;
    c.load_data = wr;  c.set_dirty = wr;
    return c;
  endfunction

  function automatic ctl_t wb_ctl(input logic v);
    ctl_t c = '0;
    c.pmem_write = 1'b1; c.pmem_addr_sel = 1'b1; c.way_sel = v;
    return c;
  endfunction

  function automatic ctl_t alloc_ctl(input logic v, input logic fill);
    ctl_t c = '0;
    c.pmem_read = 1'b1; c.way_sel = v;
    c.load_data = fill; c.data_src = fill; c.load_tag = fill; c.set_valid = fill;
    c.clr_dirty = fill;
    return c;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] h,
                       input logic [1:0] d, input logic l, input logic resp);
    bus.mem_read = rd; bus.mem_write = wr; bus.hit = h; bus.dirty = d; bus.lru = l;
    bus.pmem_resp = resp;
    #1;
  endtask

  task automatic test_reset();
    ctl_t exp;
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    next_cycle(); next_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    n_checks++;
    if (observe() !== '0) $display("FAIL reset_ctl got=%b exp=%b", observe(), 13'b0);
    else n_pass++;
    n_checks++;
    if (bus.miss_count !== 32'd0 || bus.wb_count !== 32'd0)
      $display("FAIL reset_counters got=%h/%h exp=0/0", bus.miss_count, bus.wb_count);
    else n_pass++;
    // Clean read miss into ALLOCATE, then reset mid-allocation.
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    exp = alloc_ctl(1'b0, 1'b0);
    n_checks++;
    if (observe() !== exp) $display("FAIL reset_pre_alloc got=%b exp=%b", observe(), exp);
    else n_pass++;
    n_checks++;
    if (bus.miss_count !== 32'd1)
      $display("FAIL reset_pre_miss got=%h exp=%h", bus.miss_count, 32'd1);
    else n_pass++;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    n_checks++;
    if (observe() !== '0) $display("FAIL reset_mid_alloc got=%b exp=%b", observe(), 13'b0);
    else n_pass++;
    n_checks++;
    if (bus.miss_count !== 32'd0 || bus.wb_count !== 32'd0)
      $display("FAIL reset_mid_counters got=%h/%h exp=0/0", bus.miss_count, bus.wb_count);
    else n_pass++;
    next_cycle();
    // A hit here would respond only if the FSM had wrongly left IDLE.
    drive(1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1);
    n_checks++;
    if (observe() !== '0) $display("FAIL reset_idle got=%b exp=%b", observe(), 13'b0);
    else n_pass++;
    next_cycle();
    miss_m = '0;
    wb_m   = '0;
  endtask

  task automatic test_read_hit();
    drive(1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
    n_checks++;
    if (observe() !== '0) $display("FAIL rdhit_c1 got=%b exp=%b", observe(), 13'b0);
    else n_pass++;
    next_cycle();
    drive(1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
    n_checks++;
    if (observe() !== hit_ctl(1'b1, 1'b0))
      $display("FAIL rdhit_c2 got=%b exp=%b", observe(), hit_ctl(1'b1, 1'b0));
    else n_pass++;
    next_cycle();
    drive(1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
    n_checks++;
    if (bus.mem_resp !== 1'b0) $display("FAIL rdhit_c3 mem_resp got=%b exp=0", bus.mem_resp);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_clean_miss();
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    n_checks++;
    if (observe() !== '0) $display("FAIL clean_check got=%b exp=%b", observe(), 13'b0);
    else n_pass++;
    next_cycle();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b1, k == 5);
      n_checks++;
      if (observe() !== alloc_ctl(1'b1, k == 5))
        $display("FAIL clean_alloc%0d got=%b exp=%b", k, observe(), alloc_ctl(1'b1, k == 5));
      else n_pass++;
      next_cycle();
    end
    drive(1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0);
    n_checks++;
    if (observe() !== hit_ctl(1'b1, 1'b0))
      $display("FAIL clean_recheck got=%b exp=%b", observe(), hit_ctl(1'b1, 1'b0));
    else n_pass++;
    miss_m++;
    next_cycle();
    drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    n_checks++;
    if (bus.miss_count !== miss_m || bus.wb_count !== wb_m)
      $display("FAIL clean_counters got=%h/%h exp=%h/%h", bus.miss_count, bus.wb_count,
               miss_m, wb_m);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_dirty_write_miss();
    drive(1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0);
    next_cycle();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b1, 2'b00, 2'b01, 1'b0, k == 3);
      n_checks++;
      if (observe() !== wb_ctl(1'b0))
        $display("FAIL dirty_wb%0d got=%b exp=%b", k, observe(), wb_ctl(1'b0));
      else n_pass++;
      next_cycle();
    end
    // lru flips during allocation; the victim way must not follow it.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b1, 2'b00, 2'b01, 1'b1, k == 3);
      n_checks++;
      if (observe() !== alloc_ctl(1'b0, k == 3))
        $display("FAIL dirty_alloc%0d got=%b exp=%b", k, observe(), alloc_ctl(1'b0, k == 3));
      else n_pass++;
      next_cycle();
    end
    drive(1'b0, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0);
    n_checks++;
    if (observe() !== hit_ctl(1'b0, 1'b1))
      $display("FAIL dirty_recheck got=%b exp=%b", observe(), hit_ctl(1'b0, 1'b1));
    else n_pass++;
    miss_m++;
    wb_m++;
    next_cycle();
    drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    n_checks++;
    if (bus.miss_count !== miss_m || bus.wb_count !== wb_m)
      $display("FAIL dirty_counters got=%h/%h exp=%h/%h", bus.miss_count, bus.wb_count,
               miss_m, wb_m);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_double_hit();
    drive(1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
    n_checks++;
    if (observe() !== hit_ctl(1'b0, 1'b1))
      $display("FAIL double_hit got=%b exp=%b", observe(), hit_ctl(1'b0, 1'b1));
    else n_pass++;
    next_cycle();
    drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    next_cycle();
  endtask

  task automatic test_counter_wrap();
    drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    force dut.miss_count_d = 32'hFFFF_FFFF;
    next_cycle();
    release dut.miss_count_d;
    drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    n_checks++;
    if (bus.miss_count !== 32'hFFFF_FFFF)
      $display("FAIL wrap_preload got=%h exp=%h", bus.miss_count, 32'hFFFF_FFFF);
    else n_pass++;
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    miss_m = 32'hFFFF_FFFF + 32'd1;
    n_checks++;
    if (bus.miss_count !== miss_m)
      $display("FAIL wrap_miss got=%h exp=%h", bus.miss_count, miss_m);
    else n_pass++;
    next_cycle();
    drive(1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0);
    n_checks++;
    if (observe() !== hit_ctl(1'b0, 1'b1))
      $display("FAIL rw_as_write got=%b exp=%b", observe(), hit_ctl(1'b0, 1'b1));
    else n_pass++;
    next_cycle();
    drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    next_cycle();
  endtask

  // Each request: cycle 1 IDLE, cycle 2 CHECK, then wl writeback and rl allocate cycles on a
  // miss, then the re-check that responds; the hit way follows the fill of the victim.
  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      logic rd, wr, l, miss, wb, w, lin, resp;
      logic [1:0] hv, d, hin;
      int wl, rl, last;
      ctl_t exp;
      wr   = 1'($urandom);
      rd   = wr ? 1'($urandom) : 1'b1;
      hv   = 2'($urandom_range(0, 3));
      d    = 2'($urandom);
      l    = 1'($urandom);
      wl   = $urandom_range(1, 4);
      rl   = $urandom_range(1, 4);
      miss = (hv == 2'b00);
      wb   = miss && d[l];
      w    = miss ? l : (hv[0] ? 1'b0 : 1'b1);
      if (!miss) begin wl = 0; rl = 0; end
      else if (!wb) wl = 0;
      last = miss ? 3 + wl + rl : 2;
      for (int c = 1; c <= last; c++) begin
        if (c == last && miss) hin = 2'b01 << w;
        else if (c <= 2) hin = hv;
        else hin = 2'b00;
        lin  = (c <= 2) ? l : 1'($urandom);
        if (c <= 2 || c == last) resp = (c == 1) ? 1'($urandom) : 1'b0;
        else resp = (c == 2 + wl && wb) || (c == 2 + wl + rl);
        if (c == 1) exp = '0;
        else if (c == last) exp = hit_ctl(w, wr);
        else if (c == 2) exp = '0;
        else if (c <= 2 + wl) exp = wb_ctl(l);
        else exp = alloc_ctl(l, c == 2 + wl + rl);
        drive(rd, wr, hin, d, lin, resp);
        n_checks++;
        if (observe() !== exp)
          $display("FAIL rand t=%0d c=%0d got=%b exp=%b", t, c, observe(), exp);
        else n_pass++;
        next_cycle();
      end
      miss_m += {31'b0, miss};
      wb_m   += {31'b0, wb};
      drive(1'b0, 1'b0, 2'b00, d, l, 1'b0);
      n_checks++;
      if (observe() !== '0 || bus.miss_count !== miss_m || bus.wb_count !== wb_m)
        $display("FAIL rand_idle t=%0d got=%b %h/%h exp=0 %h/%h", t, observe(),
                 bus.miss_count, bus.wb_count, miss_m, wb_m);
      else n_pass++;
      next_cycle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;
    bus.hit = 2'b00; bus.dirty = 2'b00; bus.lru = 1'b0;
    @(negedge clk);
    test_reset();
    test_read_hit();
    test_clean_miss();
    test_dirty_write_miss();
    test_double_hit();
    test_counter_wrap();
    test_random(60);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
Control FSM for the 2-way set-associative, write-back, write-allocate L1 cache. The cache has 8 sets, 256-bit lines and 24-bit tags, and sits between the CPU memory port and physical memory. The block sequences the cache datapath through hit service, dirty-victim writeback and line allocation, and maintains LRU, valid and dirty updates. It also keeps miss and writeback event counters.

Parameters:
none; geometry is fixed by the datapath (2 ways, 8 sets, 256-bit line, 24-bit tag).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
mem_read  in  1  CPU read request; held stable until mem_resp
mem_write  in  1  CPU write request; held stable until mem_resp
mem_resp  out  1  one-cycle completion pulse to CPU
pmem_read  out  1  physical memory line read
pmem_write  out  1  physical memory line write
pmem_resp  in  1  physical memory completion
hit  in  2  per-way (valid & tag match) for the indexed set
dirty  in  2  per-way dirty bits of the indexed set
lru  in  1  LRU way of the indexed set
way_sel  out  1  way targeted by data/tag/valid/dirty loads and by the writeback line mux
load_data  out  1  write the selected way's data line
data_src  out  1  0 = CPU wdata merged by byte enable; 1 = pmem_rdata full line
load_tag  out  1  write the CPU tag into the selected way
set_valid  out  1  set the selected way's valid bit
set_dirty  out  1  set the selected way's dirty bit
clr_dirty  out  1  clear the selected way's dirty bit
load_lru  out  1  write the LRU bit of the indexed set
lru_in  out  1  new LRU value
pmem_addr_sel  out  1  0 = CPU line address; 1 = victim {tag[way_sel], index}
miss_count  out  32  count of misses, wraps
wb_count  out  32  count of completed writebacks, wraps

Behaviour:
- States: IDLE, CHECK, WRITEBACK, ALLOCATE. All control outputs are decoded from state and inputs; all are 0 in IDLE.
- Reset: on any rising clk edge with rst=1, state goes to IDLE and both counters clear. This applies in every state, including mid-WRITEBACK or mid-ALLOCATE. pmem_read and pmem_write are 0 from the cycle after the reset edge. An outstanding pmem_resp is then ignored.
- IDLE: if mem_read|mem_write, go to CHECK on the next edge; otherwise stay.
- CHECK, hit (hit != 00):
  - Hit way hw = 0 if hit[0], else 1. hit = 11 is illegal; way 0 wins.
  - mem_resp = 1; load_lru = 1; lru_in = ~hw; way_sel = hw.
  - If mem_write: also load_data = 1, data_src = 0, set_dirty = 1.
  - Next state IDLE.
  - Hit latency: mem_resp 1 cycle after the request is first sampled in IDLE, i.e. in the second cycle of the request.
- CHECK, miss (hit == 00):
  - miss_count increments by 1 (wraps 0xFFFFFFFF -> 0).
  - If dirty[lru], go to WRITEBACK; else go to ALLOCATE.
  - No mem_resp in this cycle.
- WRITEBACK: way_sel = lru; pmem_addr_sel = 1; pmem_write = 1 held until pmem_resp. On the pmem_resp cycle: wb_count increments, next state ALLOCATE.
- ALLOCATE: way_sel = lru; pmem_addr_sel = 0; pmem_read = 1 held until pmem_resp. On the pmem_resp cycle: load_data = 1, data_src = 1, load_tag = 1, set_valid = 1, clr_dirty = 1, next state CHECK. The re-check then hits, and the LRU/write merge happen there.
- way_sel is captured from lru on entry to WRITEBACK and held through ALLOCATE. A later lru change does not move the victim.
- mem_read and mem_write both asserted: treated as a write.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.
- mem_resp is never asserted outside CHECK and lasts exactly one cycle per request.
- Miss penalty: clean miss = 2 + pmem latency cycles before the hit CHECK. Dirty miss additionally includes the writeback latency.

Test Plan:
1. Reset: drive rst for 1 cycle during ALLOCATE with pmem_read=1 -> next cycle pmem_read=0, state IDLE, miss_count=0, wb_count=0; a late pmem_resp=1 produces no load_data.
2. Read hit: mem_read=1, hit=10 (way 1) -> cycle 2: mem_resp=1, load_lru=1, lru_in=0, way_sel=1, load_data=0; mem_resp=0 in cycle 3.
3. Clean read miss: hit=00, lru=1, dirty=00 -> ALLOCATE with pmem_read=1, way_sel=1, pmem_addr_sel=0; pmem_resp on the 5th ALLOCATE cycle -> single-cycle pulse of load_data/data_src=1/load_tag/set_valid/clr_dirty; then with hit=10 -> mem_resp; miss_count=1, wb_count=0.
4. Dirty write miss: hit=00, lru=0, dirty=01 -> WRITEBACK with pmem_write=1, pmem_addr_sel=1, way_sel=0 until pmem_resp -> ALLOCATE; then with hit=01 -> load_data=1, data_src=0, set_dirty=1, lru_in=1, mem_resp=1; miss_count=1, wb_count=1; lru toggled to 1 mid-ALLOCATE does not change way_sel.
5. Illegal double hit: mem_write=1, hit=11 -> way_sel=0, lru_in=1, set_dirty=1, mem_resp=1.
6. Counter wrap: force miss_count=0xFFFFFFFF, then trigger a miss -> miss_count=0x00000000; mem_read=mem_write=1 with a hit -> write path taken (set_dirty=1).
